// File: rtl/sca_window_ctrl.sv
// Capture-window controller: start -> pre-delay (ARM) -> run window -> guard -> done.
// Build option WINDOW_OPZERO_EN: operands read 0 outside the RUN window.
module sca_window_ctrl #(
  parameter int DATA_W    = 24,
  parameter int CNT_W     = 8,
  parameter int GUARD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [CNT_W-1:0]  pre_dly,
  input  logic [CNT_W-1:0]  run_len,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              working_flag,
  output logic              trig,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int G_W = $clog2(GUARD_CYC + 1);
  localparam logic [G_W-1:0] GUARD_LOAD = G_W'(GUARD_CYC);

  typedef enum logic [1:0] {IDLE, ARM, RUN, GUARD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic [G_W-1:0]    gcnt_q, gcnt_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic              wf_q, wf_d;
  logic              trig_q, trig_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
`ifdef WINDOW_OPZERO_EN
  logic [DATA_W-1:0] a_out_q, a_out_d;
  logic [DATA_W-1:0] b_out_q, b_out_d;
`endif

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    rcnt_d    = rcnt_q;
    gcnt_d    = gcnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    done_d    = 1'b0;
    // A start outside IDLE never reaches the sequencer; it only latches the error flag.
    overrun_d = overrun_q | (start && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = a_in;
          op_b_d  = b_in;
          pcnt_d  = pre_dly;
          rcnt_d  = (run_len == '0) ? CNT_W'(1) : run_len;
          state_d = (pre_dly != '0) ? ARM : RUN;
        end
      end
      ARM: begin
        pcnt_d = pcnt_q - CNT_W'(1);
        if (pcnt_q == CNT_W'(1)) state_d = RUN;
      end
      RUN: begin
        rcnt_d = rcnt_q - CNT_W'(1);
        if (rcnt_q == CNT_W'(1)) begin
          state_d = GUARD;
          gcnt_d  = GUARD_LOAD;
        end
      end
      GUARD: begin
        gcnt_d = gcnt_q - G_W'(1);
        if (gcnt_q == G_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    wf_d   = (state_d == RUN);
    trig_d = (state_d == RUN) && (state_q != RUN);
    busy_d = (state_d != IDLE);
`ifdef WINDOW_OPZERO_EN
    a_out_d = (state_d == RUN) ? op_a_d : '0;
    b_out_d = (state_d == RUN) ? op_b_d : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      rcnt_q    <= '0;
      gcnt_q    <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      wf_q      <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef WINDOW_OPZERO_EN
      a_out_q   <= '0;
      b_out_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      rcnt_q    <= rcnt_d;
      gcnt_q    <= gcnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      wf_q      <= wf_d;
      trig_q    <= trig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
`ifdef WINDOW_OPZERO_EN
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
`endif
    end
  end

`ifdef WINDOW_OPZERO_EN
  assign a_out = a_out_q;
  assign b_out = b_out_q;
`else
  assign a_out = op_a_q;
  assign b_out = op_b_q;
`endif
  assign working_flag = wf_q;
  assign trig         = trig_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sca_window_ctrl.sv
// Self-checking bench for sca_window_ctrl: directed scenarios plus random traffic
// against a window-arithmetic reference model.
module tb_sca_window_ctrl;
  localparam int DW = 24;
  localparam int CW = 8;
  localparam int G  = 4;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] a_in, b_in, a_out, b_out;
  logic [CW-1:0] pre_dly, run_len;
  logic          working_flag, trig, busy, done, overrun;

  sca_window_ctrl #(.DATA_W(DW), .CNT_W(CW), .GUARD_CYC(G)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .pre_dly(pre_dly), .run_len(run_len), .a_out(a_out), .b_out(b_out),
    .working_flag(working_flag), .trig(trig), .busy(busy), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  wire [2*DW+4:0] got_vec = {a_out, b_out, working_flag, trig, busy, done, overrun};

  // Reference model: one accepted acquisition described by its accept edge and lengths.
  int            cyc = 0;
  int            m_e, m_p, m_r;
  bit            m_active = 0;
  bit            m_ovr = 0;
  logic [DW-1:0] m_a = '0, m_b = '0;
  logic [2*DW+4:0] exp_vec;
  int            checks = 0, errors = 0, txn = 0;

  function automatic bit m_busy_at(int k);
    return m_active && (k >= m_e) && (k <= m_e + m_p + m_r + G - 1);
  endfunction

  task automatic cycle(input bit s, input bit r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [CW-1:0] p, input logic [CW-1:0] rl);
    bit e_wf, e_trig, e_busy, e_done;
    logic [DW-1:0] e_a, e_b;
    @(negedge clk);
    start = s; rst = r; a_in = a; b_in = b; pre_dly = p; run_len = rl;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_active = 0; m_ovr = 0; m_a = '0; m_b = '0;
    end else if (s) begin
      if (m_busy_at(cyc - 1)) m_ovr = 1;
      else begin
        m_active = 1; m_e = cyc; m_p = int'(p); m_r = (rl == 0) ? 1 : int'(rl);
        m_a = a; m_b = b; txn++;
        $display("txn %0d cyc %0d pre=%0d run=%0d a=%h b=%h", txn, cyc, p, rl, a, b);
      end
    end
    e_wf   = m_active && (cyc >= m_e + m_p) && (cyc < m_e + m_p + m_r);
    e_trig = m_active && (cyc == m_e + m_p);
    e_busy = m_busy_at(cyc);
    e_done = m_active && (cyc == m_e + m_p + m_r + G);
`ifdef WINDOW_OPZERO_EN
    e_a = e_wf ? m_a : '0;
    e_b = e_wf ? m_b : '0;
`else
    e_a = m_a;
    e_b = m_b;
`endif
    exp_vec = {e_a, e_b, e_wf, e_trig, e_busy, e_done, m_ovr};
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 1, '0, '0, '0, '0);
    cycle(0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 24'($urandom()), 24'($urandom()), 8'($urandom()), 8'($urandom()));
      checks++;
      if (got_vec !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", cyc, got_vec);
      end
    end
  endtask

  task automatic test_basic_window();
    int trig_at = -1, done_at = -1, wf_n = 0;
    bit a_ok = 1;
    for (int i = 0; i < 16; i++) begin
      cycle(i == 0, 0, 24'h123456, 24'hABCDEF, 8'd3, 8'd6);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL basic_model cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (trig) trig_at = i;
      if (done) done_at = i;
      if (working_flag) begin
        wf_n++;
        if (a_out !== 24'h123456 || b_out !== 24'hABCDEF) a_ok = 0;
      end
    end
    checks += 4;
    if (trig_at !== 3) begin errors++; $display("FAIL basic_trig got=%0d exp=3", trig_at); end
    if (wf_n !== 6) begin errors++; $display("FAIL basic_wf_len got=%0d exp=6", wf_n); end
    if (done_at !== 13) begin errors++; $display("FAIL basic_done got=%0d exp=13", done_at); end
    if (!a_ok) begin errors++; $display("FAIL basic_operand got=%h exp=123456", a_out); end
  endtask

  task automatic test_zero_lengths();
    int trig_at = -1, done_at = -1, wf_n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(i == 0, 0, 24'h0F0F0F, 24'h5A5A5A, 8'd0, 8'd0);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL zero_model cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (trig) trig_at = i;
      if (done) done_at = i;
      if (working_flag) wf_n++;
    end
    checks += 3;
    if (trig_at !== 0) begin errors++; $display("FAIL zero_trig got=%0d exp=0", trig_at); end
    if (wf_n !== 1) begin errors++; $display("FAIL zero_wf_len got=%0d exp=1", wf_n); end
    if (done_at !== 5) begin errors++; $display("FAIL zero_done got=%0d exp=5", done_at); end
  endtask

  task automatic test_overrun();
    int done_at = -1;
    bit a_ok = 1;
    cycle(0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) cycle(1, 0, 24'h222222, 24'h333333, 8'd0, 8'd1);
      else cycle(i == 0, 0, 24'h111111, 24'h444444, 8'd2, 8'd5);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL overrun_model cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (done) done_at = i;
      if (working_flag && a_out !== 24'h111111) a_ok = 0;
    end
    checks += 3;
    if (done_at !== 11) begin errors++; $display("FAIL overrun_done got=%0d exp=11", done_at); end
    if (!a_ok) begin errors++; $display("FAIL overrun_operand got=%h exp=111111", a_out); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid_run();
    int done_n = 0, done_at = -1, wf_n = 0;
    cycle(0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 4; i++) cycle(i == 0, 0, 24'hC0FFEE, 24'hBEEF01, 8'd1, 8'd6);
    checks++;
    if (working_flag !== 1'b1) begin errors++; $display("FAIL rst_mid_in_run got=%b exp=1", working_flag); end
    cycle(0, 1, '0, '0, '0, '0);
    checks++;
    if (got_vec !== '0) begin errors++; $display("FAIL rst_mid_clear got=%h exp=0", got_vec); end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, '0, '0, '0, '0);
      if (done) done_n++;
    end
    checks++;
    if (done_n !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_n); end
    for (int i = 0; i < 12; i++) begin
      cycle(i == 0, 0, 24'h00ABCD, 24'h00DCBA, 8'd2, 8'd3);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL rst_mid_rerun cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (working_flag) wf_n++;
      if (done) done_at = i;
    end
    checks += 2;
    if (wf_n !== 3) begin errors++; $display("FAIL rst_mid_wf_len got=%0d exp=3", wf_n); end
    if (done_at !== 9) begin errors++; $display("FAIL rst_mid_done got=%0d exp=9", done_at); end
  endtask

  task automatic test_max_predelay();
    int trig_at = -1, done_at = -1, wf_n = 0;
    cycle(0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 266; i++) begin
      cycle(i == 0, 0, 24'h7E7E7E, 24'h818181, 8'd255, 8'd2);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL maxpre_model cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (trig) trig_at = i;
      if (done) done_at = i;
      if (working_flag) wf_n++;
    end
    checks += 3;
    if (trig_at !== 255) begin errors++; $display("FAIL maxpre_trig got=%0d exp=255", trig_at); end
    if (wf_n !== 2) begin errors++; $display("FAIL maxpre_wf_len got=%0d exp=2", wf_n); end
    if (done_at !== 261) begin errors++; $display("FAIL maxpre_done got=%0d exp=261", done_at); end
  endtask

  task automatic test_back_to_back();
    int trig_n = 0, done_at = -1;
    cycle(0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) cycle(1, 0, 24'h0BBBBB, 24'h0CCCCC, 8'd0, 8'd1);
      else cycle(i == 0, 0, 24'h0AAAAA, 24'h0DDDDD, 8'd1, 8'd2);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
      if (trig) trig_n++;
      if (done) done_at = i;
    end
    checks += 3;
    if (trig_n !== 2) begin errors++; $display("FAIL b2b_trig_count got=%0d exp=2", trig_n); end
    if (done_at !== 13) begin errors++; $display("FAIL b2b_done got=%0d exp=13", done_at); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_random();
    bit s, r;
    logic [CW-1:0] p, rl;
    cycle(0, 1, '0, '0, '0, '0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      s  = m_busy_at(cyc) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
      p  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 12));
      rl = 8'($urandom_range(0, 10));
      cycle(s, r, 24'($urandom()), 24'($urandom()), p, rl);
      checks++;
      if (got_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, got_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; pre_dly = '0; run_len = '0;
    test_reset();
    test_basic_window();
    test_zero_lengths();
    test_overrun();
    test_reset_mid_run();
    test_max_predelay();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
